// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a per-register pending scoreboard.
// Read data and pending flags are registered; optional same-cycle write-to-read bypass.
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NWR    = 2,
  parameter int unsigned NRD    = 4,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_pend_o,
  input  logic                stall_i,
  input  logic [NWR*AW-1:0]   rd_addr_i,
  input  logic [NWR*XLEN-1:0] rd_data_i,
  input  logic [NWR-1:0]      rd_write_i,
  input  logic [NWR*AW-1:0]   pend_addr_i,
  input  logic [NWR-1:0]      pend_set_i
);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NREGS-1:0]    pend_q, pend_d;
  logic [NREGS-1:0]    clr_mask, set_mask, pend_clr;
  logic [NRD*XLEN-1:0] rdata_d;
  logic [NRD-1:0]      rpend_d;

  // Ascending port loop: the highest-index port on a shared address wins.
  always_comb begin
    logic [AW-1:0] waddr;
    logic [AW-1:0] paddr;
    waddr    = '0;
    paddr    = '0;
    regs_d   = regs_q;
    clr_mask = '0;
    set_mask = '0;
    for (int w = 0; w < NWR; w++) begin
      waddr = rd_addr_i[w*AW +: AW];
      paddr = pend_addr_i[w*AW +: AW];
      if (rd_write_i[w]) begin
        clr_mask[waddr] = 1'b1;
        if (waddr != '0) begin
          regs_d[waddr] = rd_data_i[w*XLEN +: XLEN];
        end
      end
      if (pend_set_i[w]) begin
        set_mask[paddr] = 1'b1;
      end
    end
    clr_mask[0] = 1'b0;
    set_mask[0] = 1'b0;
    pend_clr    = pend_q & ~clr_mask;
    // A new producer issued in the same cycle as a writeback keeps the bit set.
    pend_d      = pend_clr | set_mask;
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rdata_d = '0;
    rpend_d = '0;
    for (int r = 0; r < NRD; r++) begin
      ra = rs_addr_i[r*AW +: AW];
      rdata_d[r*XLEN +: XLEN] = regs_q[ra];
      rpend_d[r] = (BYPASS != 0) ? pend_clr[ra] : pend_q[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (rd_write_i[w] && (ra != '0) && (rd_addr_i[w*AW +: AW] == ra)) begin
            rdata_d[r*XLEN +: XLEN] = rd_data_i[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q    <= '0;
      rs_data_o <= '0;
      rs_pend_o <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
      if (!stall_i) begin
        rs_data_o <= rdata_d;
        rs_pend_o <= rpend_d;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus;
// expectations are queued with the cycle they apply to and drained by a separate monitor.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NWR   = 2;
  localparam int NRD   = 4;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data_b, rs_data_n;
  logic [NRD-1:0]      rs_pend_b, rs_pend_n;
  logic                stall;
  logic [NWR*AW-1:0]   rd_addr;
  logic [NWR*XLEN-1:0] rd_data;
  logic [NWR-1:0]      rd_write;
  logic [NWR*AW-1:0]   pend_addr;
  logic [NWR-1:0]      pend_set;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .NRD(NRD), .BYPASS(1)
  ) dut_byp (
    .clock_i(clk), .reset_i(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data_b),
    .rs_pend_o(rs_pend_b), .stall_i(stall), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rd_write_i(rd_write), .pend_addr_i(pend_addr), .pend_set_i(pend_set)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .NRD(NRD), .BYPASS(0)
  ) dut_nob (
    .clock_i(clk), .reset_i(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data_n),
    .rs_pend_o(rs_pend_n), .stall_i(stall), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rd_write_i(rd_write), .pend_addr_i(pend_addr), .pend_set_i(pend_set)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          ph;     // 0: sampled at negedge, 1: sampled on probe_ev
    bit          which;  // 0: bypass instance, 1: non-bypass instance
    int          port;
    logic [31:0] data;
    logic        pend;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event probe_ev;

  task automatic drain(input bit ph);
    exp_t        e;
    logic [31:0] act_d;
    logic        act_p;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].ph == ph) begin
      e = exp_q.pop_front();
      act_d = e.which ? rs_data_n[e.port*XLEN +: XLEN] : rs_data_b[e.port*XLEN +: XLEN];
      act_p = e.which ? rs_pend_n[e.port] : rs_pend_b[e.port];
      checks++;
      if (act_d !== e.data || act_p !== e.pend) begin
        errors++;
        $display("FAIL %s: %s port %0d got data=%h pend=%b, expected data=%h pend=%b",
                 e.name, e.which ? "nobypass" : "bypass", e.port, act_d, act_p, e.data, e.pend);
      end
    end
  endtask

  always @(negedge clk) drain(1'b0);
  always @(probe_ev) drain(1'b1);

  task automatic push(input bit ph, input int c, input bit which, input int port,
                      input logic [31:0] d, input logic p, input string nm);
    exp_t e;
    e.cyc = c; e.ph = ph; e.which = which; e.port = port; e.data = d; e.pend = p; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Expectation for the outputs after the coming rising edge.
  task automatic expect_nxt(input bit which, input int port, input logic [31:0] d,
                            input logic p, input string nm);
    push(1'b0, cyc + 1, which, port, d, p, nm);
  endtask

  task automatic expect_both(input int port, input logic [31:0] d, input logic p,
                             input string nm);
    expect_nxt(1'b0, port, d, p, nm);
    expect_nxt(1'b1, port, d, p, nm);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    rd_write = '0;
    pend_set = '0;
    stall    = 1'b0;
  endtask

  task automatic set_rs(input int p, input int a);
    rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    rd_addr[w*AW +: AW]     = AW'(a);
    rd_data[w*XLEN +: XLEN] = d;
    rd_write[w]             = 1'b1;
  endtask

  task automatic pset(input int w, input int a);
    pend_addr[w*AW +: AW] = AW'(a);
    pend_set[w]           = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rs_addr = '0; stall = 1'b0; rd_addr = '0; rd_data = '0;
    rd_write = '0; pend_addr = '0; pend_set = '0;

    @(negedge clk);
    for (int p = 0; p < NRD; p++) expect_both(p, 32'h0, 1'b0, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle write and read of x3
    next_cycle();
    wr(0, 3, 32'hA5A5_A5A5); set_rs(1, 3);
    expect_nxt(1'b0, 1, 32'hA5A5_A5A5, 1'b0, "bypass_same_cycle");
    expect_nxt(1'b1, 1, 32'h0, 1'b0, "nobypass_old_value");
    next_cycle();
    expect_both(1, 32'hA5A5_A5A5, 1'b0, "x3_next_cycle");

    // Two write ports to x7: port 1 wins
    next_cycle();
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); set_rs(2, 7);
    expect_nxt(1'b0, 2, 32'h22, 1'b0, "conflict_bypass");
    expect_nxt(1'b1, 2, 32'h0, 1'b0, "conflict_nobypass_old");
    next_cycle();
    expect_both(2, 32'h22, 1'b0, "conflict_high_port_wins");

    // x0 is never written nor marked pending
    next_cycle();
    for (int p = 0; p < NRD; p++) set_rs(p, 0);
    wr(0, 0, 32'hFFFF_FFFF); wr(1, 0, 32'hFFFF_FFFF); pset(0, 0);
    for (int p = 0; p < NRD; p++) expect_both(p, 32'h0, 1'b0, "x0_write_cycle");
    next_cycle();
    for (int p = 0; p < NRD; p++) expect_both(p, 32'h0, 1'b0, "x0_after");

    // Scoreboard on x9
    next_cycle();
    set_rs(0, 9); pset(0, 9);
    expect_both(0, 32'h0, 1'b0, "pend_set_not_yet_visible");
    next_cycle();
    expect_both(0, 32'h0, 1'b1, "pend_set_visible");
    next_cycle();
    wr(1, 9, 32'h99); pset(0, 9);
    expect_nxt(1'b0, 0, 32'h99, 1'b0, "setclr_bypass_sees_clear");
    expect_nxt(1'b1, 0, 32'h0, 1'b1, "setclr_nobypass_pre_update");
    next_cycle();
    expect_both(0, 32'h99, 1'b1, "set_wins_over_clear");
    next_cycle();
    wr(0, 9, 32'h123);
    expect_nxt(1'b0, 0, 32'h123, 1'b0, "clear_bypass");
    expect_nxt(1'b1, 0, 32'h99, 1'b1, "clear_nobypass");
    next_cycle();
    expect_both(0, 32'h123, 1'b0, "clear_settled");

    // Stall holds outputs while writes and scoreboard keep updating
    next_cycle();
    wr(0, 4, 32'h10); set_rs(3, 4);
    expect_nxt(1'b0, 3, 32'h10, 1'b0, "x4_bypass");
    expect_nxt(1'b1, 3, 32'h0, 1'b0, "x4_nobypass_old");
    next_cycle();
    expect_both(3, 32'h10, 1'b0, "x4_read");
    next_cycle();
    stall = 1'b1; wr(0, 4, 32'h20); pset(1, 4); set_rs(3, 7);
    expect_both(3, 32'h10, 1'b0, "stall_hold");
    next_cycle();
    stall = 1'b1; set_rs(3, 4);
    expect_both(3, 32'h10, 1'b0, "stall_hold2");
    next_cycle();
    expect_both(3, 32'h20, 1'b1, "after_stall");

    // Reset asserted between edges while a write is presented
    next_cycle();
    set_rs(0, 5); wr(0, 5, 32'hDEAD_BEEF);
    expect_nxt(1'b0, 0, 32'hDEAD_BEEF, 1'b0, "x5_bypass");
    expect_nxt(1'b1, 0, 32'h0, 1'b0, "x5_nobypass_old");
    next_cycle();
    wr(0, 5, 32'hCAFE_F00D); pset(1, 5);
    for (int p = 0; p < NRD; p++) begin
      push(1'b1, cyc, 1'b0, p, 32'h0, 1'b0, "async_reset_bypass");
      push(1'b1, cyc, 1'b1, p, 32'h0, 1'b0, "async_reset_nobypass");
    end
    #2 rst = 1'b1;
    #1 -> probe_ev;
    expect_both(0, 32'h0, 1'b0, "reset_held");
    next_cycle();
    rst = 1'b0; set_rs(1, 3);
    expect_both(0, 32'h0, 1'b0, "x5_after_reset");
    expect_both(1, 32'h0, 1'b0, "x3_after_reset");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      checks += exp_q.size();
      errors += exp_q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
